// File: rtl/lsu_pkg.sv
// LSU shared types: funct3 and FSM state enums, store lane helpers.
// Imported by load_align and lsu.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    function automatic logic f3_illegal(
        input logic       we,
        input logic [2:0] f3
    );
        logic bad;
        unique case (1'b1)
            f3 == LSU_B,
            f3 == LSU_H,
            f3 == LSU_W:  bad = 1'b0;
            f3 == LSU_BU,
            f3 == LSU_HU: bad = we;
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        return (f3[1:0] == 2'b01 && lo[0])
            || (f3[1:0] == 2'b10 && lo != 2'b00);
    endfunction

    function automatic logic [3:0] st_strb(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic [3:0] s;
        unique case (1'b1)
            f3[1:0] == 2'b00: s = 4'b0001 << lo;
            f3[1:0] == 2'b01: s = 4'b0011 << {lo[1], 1'b0};
            default:          s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] st_data(
        input logic [2:0]  f3,
        input logic [31:0] d
    );
        logic [31:0] r;
        unique case (1'b1)
            f3[1:0] == 2'b00: r = {4{d[7:0]}};
            f3[1:0] == 2'b01: r = {2{d[15:0]}};
            default:          r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension (combinational).
// Ports: word, addr_lo, funct3 -> result.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = word[{addr_lo, 3'b000} +: 8];
        h      = addr_lo[1] ? word[31:16] : word[15:0];
        result = '0;
        unique case (1'b1)
            funct3 == LSU_B:  result = {{24{b[7]}}, b};
            funct3 == LSU_H:  result = {{16{h[15]}}, h};
            funct3 == LSU_W:  result = word;
            funct3 == LSU_BU: result = {24'd0, b};
            funct3 == LSU_HU: result = {16'd0, h};
            default:          result = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: request -> data memory -> aligned response FSM.
// Ports: req_* in, resp_* out, mem_* data-memory side; clk, rst (sync high).
// Option: LSU_MISALIGN_TRAP_EN faults misaligned H/W accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_e      state;
    logic            q_we;
    logic            q_bad;
    logic [2:0]      q_f3;
    logic [1:0]      q_lo;
    logic            bad_req;
    logic [31:0]     ld_data;

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad_req = f3_illegal(req_we, req_funct3)
                   | misaligned(req_funct3, req_addr[1:0]);
`else
    assign bad_req = f3_illegal(req_we, req_funct3);
`endif

    assign req_ready = (state == S_IDLE) && !rst;

    load_align u_align (
        .word    (mem_rdata),
        .addr_lo (q_lo),
        .funct3  (q_f3),
        .result  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            q_we       <= 1'b0;
            q_bad      <= 1'b0;
            q_f3       <= '0;
            q_lo       <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state     <= S_REQ;
                        q_we      <= req_we;
                        q_bad     <= bad_req;
                        q_f3      <= req_funct3;
                        q_lo      <= req_addr[1:0];
                        mem_req   <= !bad_req;
                        mem_we    <= req_we && !bad_req;
                        mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata <= st_data(req_funct3, req_wdata);
                        mem_wstrb <= (req_we && !bad_req)
                                   ? st_strb(req_funct3, req_addr[1:0])
                                   : 4'b0000;
                    end
                end
                S_REQ: begin
                    // Faulting accesses never reach memory.
                    if (q_bad) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else if (mem_gnt) begin
                        state     <= S_WAIT;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= q_we ? '0 : ld_data;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus random traffic
// against a byte-lane arithmetic model of the access rules.
`timescale 1ns/1ps
module tb_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    // Access size in bytes.
    function automatic int sz(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_err(
        input bit we, input logic [2:0] f3, input logic [31:0] a
    );
        bit legal;
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010)
             || (!we && (f3 == 3'b100 || f3 == 3'b101));
        if (!legal) return 1'b1;
        if (TRAP_EN && (int'(a % 4) % sz(f3)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Byte offset of the accessed lane, low bits below size ignored.
    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        int lo;
        lo = int'(a % 4);
        return lo - (lo % sz(f3));
    endfunction

    function automatic logic [3:0] m_strb(
        input bit we, input logic [2:0] f3, input logic [31:0] a
    );
        int v;
        if (!we) return 4'b0000;
        v = ((1 << sz(f3)) - 1) << m_off(f3, a);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(
        input logic [2:0] f3, input logic [31:0] d
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = d[8*(i % sz(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(
        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w
    );
        longint mask;
        longint v;
        int     bits;
        bits = 8 * sz(f3);
        mask = (longint'(1) << bits) - 1;
        v    = (longint'(w) >> (8 * m_off(f3, a))) & mask;
        if (!f3[2] && bits < 32 && ((v >> (bits - 1)) & 1) == 1)
            v = v | (~mask);
        return v[31:0];
    endfunction

    task automatic do_txn(
        input  bit          we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] word,
        input  int          gnt_dly,
        input  int          rv_dly,
        input  int          rr_dly,
        output logic [31:0] got
    );
        bit          e_err;
        logic [31:0] e_rd;
        int          e_lat;
        int          phase;
        int          n;
        int          cyc;
        int          lat;
        bit          done;
        e_err = m_err(we, f3, addr);
        e_rd  = (e_err || we) ? 32'h0 : m_load(f3, addr, word);
        e_lat = e_err ? 2 : 3 + gnt_dly + rv_dly;
        got   = 'x;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        check("ready_idle", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        phase = 0;
        n     = 0;
        cyc   = 0;
        lat   = -1;
        done  = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            resp_ready = 1'b0;
            mem_rdata  = $urandom;
            case (phase)
                0: begin
                    check("busy", req_ready, 0);
                    check("no_resp_req", resp_valid, 0);
                    if (e_err) begin
                        check("no_mreq_err", mem_req, 0);
                        phase = 2;
                    end else begin
                        check("mreq", mem_req, 1);
                        check("maddr", mem_addr, {addr[31:2], 2'b00});
                        check("mwe", mem_we, we);
                        check("mstrb", mem_wstrb, m_strb(we, f3, addr));
                        if (we) check("mwdata", mem_wdata, m_wdata(f3, wdata));
                        if (n == gnt_dly) begin
                            mem_gnt = 1'b1;
                            phase   = 1;
                            n       = 0;
                        end else n++;
                    end
                    if ($urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
                end
                1: begin
                    check("busy", req_ready, 0);
                    check("no_resp_wait", resp_valid, 0);
                    check("mreq_drop", mem_req, 0);
                    if (n == rv_dly) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = word;
                        phase      = 2;
                        n          = 0;
                    end else n++;
                end
                2: begin
                    check("busy", req_ready, 0);
                    check("resp_valid", resp_valid, 1);
                    if (lat < 0) begin
                        lat = cyc;
                        check("latency", lat, e_lat);
                    end
                    check("rdata", resp_rdata, e_rd);
                    check("err", resp_err, e_err);
                    got = resp_rdata;
                    if (!e_err) check("mreq_idle", mem_req, 0);
                    if ($urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
                    if (n == rr_dly) begin
                        resp_ready = 1'b1;
                        phase      = 3;
                    end else n++;
                end
                default: begin
                    check("resp_drop", resp_valid, 0);
                    check("ready_back", req_ready, 1);
                    done = 1'b1;
                end
            endcase
        end
        if (!done) check("timeout", 0, 1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_mreq"}, mem_req, 0);
        check({tag, "_rvalid"}, resp_valid, 0);
        check({tag, "_mwe"}, mem_we, 0);
        check({tag, "_mstrb"}, mem_wstrb, 0);
        check({tag, "_err"}, resp_err, 0);
        check({tag, "_rdata"}, resp_rdata, 0);
        check({tag, "_maddr"}, mem_addr, 0);
        check({tag, "_mwdata"}, mem_wdata, 0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] w;

        // Reset for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outs("rst");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);

        // LB from the top lane, zero-wait memory.
        do_txn(0, 3'b000, 32'h0000_1003, 0, 32'h80FF_0000, 0, 0, 0, got);
        check("lb_value", got, 32'hFFFF_FF80);

        // SH to the upper half.
        do_txn(1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 0, 0, 0, 0, got);
        check("sh_rdata", got, 32'h0);

        // Backpressure everywhere.
        do_txn(0, 3'b101, 32'h0000_0102, 0, 32'hC001_7F00, 4, 3, 2, got);
        check("lhu_value", got, 32'h0000_C001);

        // Misaligned LW.
        do_txn(0, 3'b010, 32'h0000_3001, 0, 32'h1234_5678, 0, 0, 0, got);
        check("lw_mis", got, TRAP_EN ? 32'h0 : 32'h1234_5678);

        // Illegal funct3 and LBU-as-store.
        do_txn(0, 3'b011, 32'h0000_0010, 0, 32'h1, 0, 0, 1, got);
        do_txn(1, 3'b100, 32'h0000_0010, 32'hFF, 0, 0, 0, 0, got);

        // Reset while waiting for memory data.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0040;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rif_mreq", mem_req, 1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check_reset_outs("rif");
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            check("rif_no_resp", resp_valid, 0);
            check("rif_ready", req_ready, 1);
        end
        do_txn(0, 3'b010, 32'h0000_0044, 0, 32'hA5A5_0F0F, 0, 1, 0, got);
        check("rif_next_lw", got, 32'hA5A5_0F0F);

        // Random traffic.
        for (int k = 0; k < 60; k++) begin
            w = $urandom;
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom, $urandom, w,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
